memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline; consumes the EX-stage results (control bits, ALU result,
//  store data, destination register). Holds the EX/MEM pipeline register, acts as the initiator side
//  of a req/ack data-memory handshake with variable wait states, and stalls upstream until the access
//  completes. Drives the MEM/WB register, plus forwarding taps to the hazard unit.
// PARAMETERS
//  DATA_WIDTH   32  width of ALU result, store data, load data
//  MEM_TIMEOUT  64  max cycles memReqOutput may stay high without ack before abort; 0 = no timeout
// PORTS
//  clk                     in   1   clock, all state on rising edge
//  reset                   in   1   synchronous, active-high
//  memToRegInput           in   1   EX: writeback selects load data
//  regWriteInput           in   1   EX: instruction writes register file
//  memWriteInput           in   1   EX: store
//  memReadInput            in   1   EX: load
//  aluResultInput          in   32  EX: ALU result / effective address
//  memWriteDataInput       in   32  EX: forwarded rt data for stores
//  regWriteRegisterInput   in   5   EX: destination register
//  memReqOutput            out  1   data-memory request
//  memWeOutput             out  1   1 = write, 0 = read; valid while memReqOutput=1
//  memAddrOutput           out  32  word address (byte address, [1:0]=0)
//  memWdataOutput          out  32  store data
//  memAckInput             in   1   memory completes current request this cycle
//  memRdataInput           in   32  load data, valid when memAckInput=1 on a read
//  stallOutput             out  1   freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//  aluResultMemOutput      out  32  forwarding tap: EX/MEM ALU result
//  regWriteMemOutput       out  1   forwarding tap: EX/MEM regWrite
//  regWriteRegisterMemOutput out 5  forwarding tap: EX/MEM destination
//  memToRegOutput          out  1   MEM/WB: memToReg
//  regWriteOutput          out  1   MEM/WB: regWrite (gated, see faults)
//  memReadDataOutput       out  32  MEM/WB: load data; 0 for non-loads
//  aluResultOutput         out  32  MEM/WB: ALU result
//  regWriteRegisterOutput  out  5   MEM/WB: destination register
//  errorOutput             out  1   MEM/WB: 1 while the faulted instruction is in MEM/WB
// BEHAVIOUR
//  - Reset: EX/MEM and MEM/WB registers, all outputs, timeout counter -> 0; FSM -> IDLE.
//    Reset mid-access abandons it; memReqOutput low the cycle after reset is sampled.
//  - EX/MEM captures all EX inputs when stallOutput=0, holds when 1.
//  - memOp = memRead|memWrite of EX/MEM; misaligned = memOp & aluResult[1:0]!=0.
//  - memWrite & memRead both set: write performed, load data forced 0.
//  - FSM IDLE: memOp & aligned -> memReqOutput=1 combinationally; ack same cycle completes
//    (zero-wait, no stall); else stallOutput=1, -> ACCESS, counter=1.
//  - FSM ACCESS: memReqOutput=1, addr/we/wdata stable from EX/MEM; stallOutput=~memAckInput;
//    ack -> complete, -> IDLE, counter=0; else counter++; counter==MEM_TIMEOUT -> abort:
//    complete as fault, -> IDLE, stall drops in that cycle.
//  - memAckInput ignored when memReqOutput=0.
//  - Non-memOp or misaligned: no request, completes in 1 cycle.
//  - MEM/WB on completion: captures memToReg, aluResult, dest, rdata (loads only, else 0);
//    regWrite = regWrite & ~fault; errorOutput = fault (misaligned or timeout).
//  - MEM/WB while stallOutput=1: bubble (regWrite=0, memToReg=0, errorOutput=0).
//  - Latency: non-stalled instruction in EX/MEM at cycle N appears at MEM/WB at N+1.
//  - Back-to-back memOps: next request may be issued the cycle after completion.
// TESTING
//  1. Reset 2 cycles -> all outputs 0, memReqOutput=0, stallOutput=0.
//  2. lw addr 0x100, ack same cycle rdata 0xDEADBEEF -> next cycle memReadDataOutput=0xDEADBEEF,
//     regWriteOutput=1, stallOutput never high.
//  3. sw addr 0x200 data 0x12345678, ack after 3 waits -> memReq high 4 cycles, addr/wdata stable,
//     stall high 3 cycles, WB sees 3 bubbles then store with regWriteOutput=0.
//  4. lw addr 0x102 -> no memReqOutput, errorOutput=1 for 1 cycle, regWriteOutput=0.
//  5. MEM_TIMEOUT=4, lw never acked -> stall 4 cycles, then errorOutput=1, memReqOutput drops.
//  6. Reset during ACCESS -> memReqOutput=0 next cycle, FSM IDLE; following lw completes normally.

Source files
------------

// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, req/ack data-memory initiator with
// wait-state stalling and timeout abort, MEM/WB register and forwarding taps.
module memory_access_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memToRegInput,
    input  logic                  regWriteInput,
    input  logic                  memWriteInput,
    input  logic                  memReadInput,
    input  logic [DATA_WIDTH-1:0] aluResultInput,
    input  logic [DATA_WIDTH-1:0] memWriteDataInput,
    input  logic [4:0]            regWriteRegisterInput,
    output logic                  memReqOutput,
    output logic                  memWeOutput,
    output logic [DATA_WIDTH-1:0] memAddrOutput,
    output logic [DATA_WIDTH-1:0] memWdataOutput,
    input  logic                  memAckInput,
    input  logic [DATA_WIDTH-1:0] memRdataInput,
    output logic                  stallOutput,
    output logic [DATA_WIDTH-1:0] aluResultMemOutput,
    output logic                  regWriteMemOutput,
    output logic [4:0]            regWriteRegisterMemOutput,
    output logic                  memToRegOutput,
    output logic                  regWriteOutput,
    output logic [DATA_WIDTH-1:0] memReadDataOutput,
    output logic [DATA_WIDTH-1:0] aluResultOutput,
    output logic [4:0]            regWriteRegisterOutput,
    output logic                  errorOutput
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t           r_state, w_nextState;
    logic [CNT_W-1:0] r_count, w_nextCount;

    logic                  r_memToReg, r_regWrite, r_memWrite, r_memRead;
    logic [DATA_WIDTH-1:0] r_aluResult, r_writeData;
    logic [4:0]            r_destReg;

    logic                  r_wbMemToReg, r_wbRegWrite, r_wbError;
    logic [DATA_WIDTH-1:0] r_wbReadData, r_wbAluResult;
    logic [4:0]            r_wbDestReg;

    logic                  w_memOp, w_misaligned, w_access, w_isLoad;
    logic                  w_req, w_stall, w_timeout, w_fault;
    logic [DATA_WIDTH-1:0] w_loadData;

    assign w_memOp      = r_memRead | r_memWrite;
    assign w_misaligned = w_memOp & (r_aluResult[1:0] != 2'b00);
    assign w_access     = w_memOp & ~w_misaligned;
    assign w_isLoad     = r_memRead & ~r_memWrite;

    // An ack always beats the timeout when both land in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_req = 1'b1;
                    if (!memAckInput) begin
                        w_stall     = 1'b1;
                        w_nextState = ACCESS;
                        w_nextCount = CNT_W'(1);
                    end
                end
            end
            ACCESS: begin
                w_req = 1'b1;
                if (memAckInput) begin
                    w_nextState = IDLE;
                    w_nextCount = '0;
                end else if ((MEM_TIMEOUT != 0) && (r_count == CNT_W'(MEM_TIMEOUT))) begin
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                    w_nextCount = '0;
                end else begin
                    w_stall     = 1'b1;
                    w_nextCount = r_count + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCount = '0;
            end
        endcase
    end

    assign w_fault    = w_misaligned | w_timeout;
    assign w_loadData = (w_isLoad && w_req && memAckInput) ? memRdataInput : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_memToReg  <= 1'b0;
            r_regWrite  <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memRead   <= 1'b0;
            r_aluResult <= '0;
            r_writeData <= '0;
            r_destReg   <= '0;
        end else if (!w_stall) begin
            r_memToReg  <= memToRegInput;
            r_regWrite  <= regWriteInput;
            r_memWrite  <= memWriteInput;
            r_memRead   <= memReadInput;
            r_aluResult <= aluResultInput;
            r_writeData <= memWriteDataInput;
            r_destReg   <= regWriteRegisterInput;
        end
    end

    // Every cycle without a stall is a completion; stalled cycles push a bubble.
    always_ff @(posedge clk) begin
        if (reset || w_stall) begin
            r_wbMemToReg  <= 1'b0;
            r_wbRegWrite  <= 1'b0;
            r_wbError     <= 1'b0;
            r_wbReadData  <= '0;
            r_wbAluResult <= '0;
            r_wbDestReg   <= '0;
        end else begin
            r_wbMemToReg  <= r_memToReg;
            r_wbRegWrite  <= r_regWrite & ~w_fault;
            r_wbError     <= w_fault;
            r_wbReadData  <= w_loadData;
            r_wbAluResult <= r_aluResult;
            r_wbDestReg   <= r_destReg;
        end
    end

    assign memReqOutput   = w_req;
    assign memWeOutput    = w_req & r_memWrite;
    assign memAddrOutput  = w_req ? r_aluResult : '0;
    assign memWdataOutput = w_req ? r_writeData : '0;
    assign stallOutput    = w_stall;

    assign aluResultMemOutput        = r_aluResult;
    assign regWriteMemOutput         = r_regWrite;
    assign regWriteRegisterMemOutput = r_destReg;

    assign memToRegOutput         = r_wbMemToReg;
    assign regWriteOutput         = r_wbRegWrite;
    assign memReadDataOutput      = r_wbReadData;
    assign aluResultOutput        = r_wbAluResult;
    assign regWriteRegisterOutput = r_wbDestReg;
    assign errorOutput            = r_wbError;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios with literal expectations, then random
// instructions and random memory wait states checked against a transaction-level model.
module tb_memory_access_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memToRegInput, regWriteInput, memWriteInput, memReadInput;
    logic [31:0] aluResultInput, memWriteDataInput;
    logic [4:0]  regWriteRegisterInput;
    logic        memReqOutput, memWeOutput;
    logic [31:0] memAddrOutput, memWdataOutput;
    logic        memAckInput;
    logic [31:0] memRdataInput;
    logic        stallOutput;
    logic [31:0] aluResultMemOutput;
    logic        regWriteMemOutput;
    logic [4:0]  regWriteRegisterMemOutput;
    logic        memToRegOutput, regWriteOutput, errorOutput;
    logic [31:0] memReadDataOutput, aluResultOutput;
    logic [4:0]  regWriteRegisterOutput;

    always #5 clk = ~clk;

    memory_access_stage #(.DATA_WIDTH(32), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .memToRegInput(memToRegInput), .regWriteInput(regWriteInput),
        .memWriteInput(memWriteInput), .memReadInput(memReadInput),
        .aluResultInput(aluResultInput), .memWriteDataInput(memWriteDataInput),
        .regWriteRegisterInput(regWriteRegisterInput),
        .memReqOutput(memReqOutput), .memWeOutput(memWeOutput),
        .memAddrOutput(memAddrOutput), .memWdataOutput(memWdataOutput),
        .memAckInput(memAckInput), .memRdataInput(memRdataInput),
        .stallOutput(stallOutput),
        .aluResultMemOutput(aluResultMemOutput), .regWriteMemOutput(regWriteMemOutput),
        .regWriteRegisterMemOutput(regWriteRegisterMemOutput),
        .memToRegOutput(memToRegOutput), .regWriteOutput(regWriteOutput),
        .memReadDataOutput(memReadDataOutput), .aluResultOutput(aluResultOutput),
        .regWriteRegisterOutput(regWriteRegisterOutput), .errorOutput(errorOutput)
    );

    // One instruction plus how the bench's memory will answer it (waits = cycles before ack).
    typedef struct packed {
        logic        memToReg;
        logic        regWrite;
        logic        memWrite;
        logic        memRead;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  dest;
        logic [7:0]  waits;
        logic [31:0] rdata;
    } instr_t;

    typedef struct packed {
        logic        bubble;
        logic        memToReg;
        logic        regWrite;
        logic        error;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  dest;
    } wb_t;

    instr_t directedQ[$];
    instr_t cur, nxt;
    int     age;
    bit     capturePending;
    wb_t    expWb;
    int     assertCount = 0;
    int     failCount = 0;

    task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic instr_t makeInstr(input logic memToReg, input logic regWrite,
                                         input logic memWrite, input logic memRead,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         input logic [4:0] dest, input logic [7:0] waits,
                                         input logic [31:0] rdata);
        instr_t i;
        i.memToReg = memToReg;
        i.regWrite = regWrite;
        i.memWrite = memWrite;
        i.memRead  = memRead;
        i.addr     = addr;
        i.wdata    = wdata;
        i.dest     = dest;
        i.waits    = waits;
        i.rdata    = rdata;
        return i;
    endfunction

    // Mix of loads, stores, load+store, ALU ops; a quarter misaligned; waits straddle the timeout.
    function automatic instr_t randomInstr();
        instr_t i;
        int     kind;
        i = '0;
        kind = int'($urandom_range(0, 9));
        i.addr = $urandom;
        if ($urandom_range(0, 3) != 0) i.addr[1:0] = 2'b00;
        i.wdata = $urandom;
        i.rdata = $urandom;
        i.dest  = 5'($urandom);
        i.waits = 8'($urandom_range(0, 6));
        if (kind <= 3) begin
            i.memRead = 1'b1; i.memToReg = 1'b1; i.regWrite = 1'b1;
        end else if (kind <= 6) begin
            i.memWrite = 1'b1;
        end else if (kind == 7) begin
            i.memRead = 1'b1; i.memWrite = 1'b1; i.memToReg = 1'b1; i.regWrite = 1'($urandom);
        end else begin
            i.regWrite = 1'b1;
        end
        return i;
    endfunction

    function automatic instr_t nextInstr();
        instr_t i;
        if (directedQ.size() > 0) i = directedQ.pop_front();
        else i = randomInstr();
        return i;
    endfunction

    task automatic applyStimulus(input instr_t i);
        memToRegInput         = i.memToReg;
        regWriteInput         = i.regWrite;
        memWriteInput         = i.memWrite;
        memReadInput          = i.memRead;
        aluResultInput        = i.addr;
        memWriteDataInput     = i.wdata;
        regWriteRegisterInput = i.dest;
    endtask

    task automatic checkOutput();
        checkBit("wb.regWrite", regWriteOutput, expWb.regWrite);
        checkBit("wb.memToReg", memToRegOutput, expWb.memToReg);
        checkBit("wb.error", errorOutput, expWb.error);
        if (!expWb.bubble) begin
            checkWord("wb.alu", aluResultOutput, expWb.alu);
            checkWord("wb.rdata", memReadDataOutput, expWb.rdata);
            checkWord("wb.dest", {27'b0, regWriteRegisterOutput}, {27'b0, expWb.dest});
        end
    endtask

    // One clock of the model: who is in EX/MEM, how the memory answers, what WB sees next.
    task automatic runCycle();
        bit access, misaligned, ackNow, abortNow, done, fault;
        @(posedge clk);
        #1;
        if (capturePending) begin
            cur = nxt;
            age = 0;
            capturePending = 0;
            nxt = nextInstr();
            applyStimulus(nxt);
        end else begin
            age++;
        end
        checkOutput();
        checkWord("fwd.alu", aluResultMemOutput, cur.addr);
        checkBit("fwd.regWrite", regWriteMemOutput, cur.regWrite);
        checkWord("fwd.dest", {27'b0, regWriteRegisterMemOutput}, {27'b0, cur.dest});

        misaligned = (cur.memRead || cur.memWrite) && (cur.addr[1:0] != 2'b00);
        access     = (cur.memRead || cur.memWrite) && !misaligned;
        ackNow     = access && (age == int'(cur.waits));
        abortNow   = access && !ackNow && (age == TIMEOUT);
        done       = !access || ackNow || abortNow;

        if (access) begin
            memAckInput   = ackNow;
            memRdataInput = ackNow ? cur.rdata : $urandom;
        end else begin
            memAckInput   = 1'($urandom);
            memRdataInput = $urandom;
        end
        #1;
        checkBit("memReq", memReqOutput, access);
        checkBit("stall", stallOutput, !done);
        if (access) begin
            checkBit("memWe", memWeOutput, cur.memWrite);
            checkWord("memAddr", memAddrOutput, cur.addr);
            checkWord("memWdata", memWdataOutput, cur.wdata);
        end

        expWb = '0;
        if (done) begin
            fault          = misaligned || abortNow;
            expWb.memToReg = cur.memToReg;
            expWb.regWrite = cur.regWrite && !fault;
            expWb.error    = fault;
            expWb.alu      = cur.addr;
            expWb.dest     = cur.dest;
            expWb.rdata    = (cur.memRead && !cur.memWrite && !fault) ? cur.rdata : 32'h0;
            capturePending = 1;
        end else begin
            expWb.bubble = 1'b1;
        end
    endtask

    // After reset the EX/MEM register holds a no-op, so the next edge captures whatever is driven.
    task automatic doReset(input int cycles);
        reset = 1'b1;
        memAckInput = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        cur = '0;
        age = 0;
        capturePending = 1;
        expWb = '0;
        checkBit("rst.memReq", memReqOutput, 1'b0);
        checkBit("rst.stall", stallOutput, 1'b0);
        checkBit("rst.regWrite", regWriteOutput, 1'b0);
        checkBit("rst.error", errorOutput, 1'b0);
        checkBit("rst.memToReg", memToRegOutput, 1'b0);
        checkWord("rst.rdata", memReadDataOutput, 32'h0);
        checkWord("rst.alu", aluResultOutput, 32'h0);
        checkWord("rst.fwdAlu", aluResultMemOutput, 32'h0);
        checkBit("rst.fwdRegWrite", regWriteMemOutput, 1'b0);
        checkWord("rst.memAddr", memAddrOutput, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int reqCount;
        int stallCount;
        memAckInput   = 1'b0;
        memRdataInput = 32'h0;

        directedQ.push_back(makeInstr(1, 1, 0, 1, 32'h100, 32'h0, 5'd8, 8'd0, 32'hDEADBEEF));
        directedQ.push_back(makeInstr(0, 0, 1, 0, 32'h200, 32'h12345678, 5'd0, 8'd3, 32'h0));
        directedQ.push_back(makeInstr(1, 1, 0, 1, 32'h102, 32'h0, 5'd10, 8'd0, 32'h11111111));
        directedQ.push_back(makeInstr(1, 1, 0, 1, 32'h400, 32'h0, 5'd11, 8'd99, 32'h22222222));
        directedQ.push_back(makeInstr(0, 1, 0, 0, 32'h55, 32'h0, 5'd9, 8'd0, 32'h0));
        directedQ.push_back(makeInstr(1, 1, 0, 1, 32'h300, 32'h0, 5'd12, 8'd10, 32'h33333333));
        directedQ.push_back(makeInstr(1, 1, 0, 1, 32'h304, 32'h0, 5'd13, 8'd1, 32'hCAFEF00D));

        nxt = nextInstr();
        applyStimulus(nxt);
        doReset(2);

        // Zero-wait load: acked in the request cycle, never stalls.
        runCycle();
        checkBit("lw0.stall", stallOutput, 1'b0);
        checkBit("lw0.memReq", memReqOutput, 1'b1);
        runCycle();
        checkWord("lw0.rdata", memReadDataOutput, 32'hDEADBEEF);
        checkBit("lw0.regWrite", regWriteOutput, 1'b1);
        checkWord("lw0.dest", {27'b0, regWriteRegisterOutput}, 32'd8);

        // Store acked after three wait states.
        reqCount = 0;
        stallCount = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) runCycle();
            reqCount += int'(memReqOutput);
            stallCount += int'(stallOutput);
            checkWord("sw.addr", memAddrOutput, 32'h200);
            checkWord("sw.wdata", memWdataOutput, 32'h12345678);
        end
        checkWord("sw.reqCycles", 32'(reqCount), 32'd4);
        checkWord("sw.stallCycles", 32'(stallCount), 32'd3);
        runCycle();
        checkWord("sw.wbAlu", aluResultOutput, 32'h200);
        checkBit("sw.wbRegWrite", regWriteOutput, 1'b0);
        checkBit("lwMis.memReq", memReqOutput, 1'b0);
        checkBit("lwMis.stall", stallOutput, 1'b0);

        // Misaligned load faults for exactly one WB cycle; then a load that is never acked.
        runCycle();
        checkBit("lwMis.error", errorOutput, 1'b1);
        checkBit("lwMis.regWrite", regWriteOutput, 1'b0);
        stallCount = int'(stallOutput);
        runCycle();
        checkBit("lwMis.errorGone", errorOutput, 1'b0);
        stallCount += int'(stallOutput);
        repeat (2) begin
            runCycle();
            stallCount += int'(stallOutput);
        end
        runCycle();
        checkBit("tmo.abortStall", stallOutput, 1'b0);
        checkBit("tmo.abortReq", memReqOutput, 1'b1);
        checkWord("tmo.stallCycles", 32'(stallCount), 32'd4);
        runCycle();
        checkBit("tmo.error", errorOutput, 1'b1);
        checkBit("tmo.memReqDrop", memReqOutput, 1'b0);
        checkBit("tmo.regWrite", regWriteOutput, 1'b0);
        checkWord("tmo.rdata", memReadDataOutput, 32'h0);

        // Reset lands while a load is waiting; the following load must still complete.
        runCycle();
        checkWord("alu.wbAlu", aluResultOutput, 32'h55);
        checkBit("alu.error", errorOutput, 1'b0);
        runCycle();
        checkBit("rstAcc.memReqBefore", memReqOutput, 1'b1);
        checkBit("rstAcc.stallBefore", stallOutput, 1'b1);
        doReset(1);
        repeat (3) runCycle();
        checkWord("rstAcc.nextRdata", memReadDataOutput, 32'hCAFEF00D);
        checkWord("rstAcc.nextAlu", aluResultOutput, 32'h304);
        checkBit("rstAcc.nextRegWrite", regWriteOutput, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) doReset(1 + int'($urandom_range(0, 1)));
            else runCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
